// File: rtl/accel_pkg.sv
// Shared types for the accelerator output path: router FSM states and tile sizing.
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    DRAIN,
    DONE
  } state_t;

  function automatic int tile_words(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/output_router_if.sv
// Controller/array-facing bundle of the output router plus its output-memory write port.
interface output_router_if #(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                            i_psum_out_en;
  logic                            i_en;
  logic [ROWS*COLS*DATA_WIDTH-1:0] i_psum;
  logic [ADDR_WIDTH-1:0]           i_route_size;
  logic                            o_valid;
  logic [ADDR_WIDTH-1:0]           o_addr;
  logic [DATA_WIDTH-1:0]           o_data;
  logic                            o_done;
  logic                            o_overrun;

  modport master (
    output i_psum_out_en, i_en, i_psum, i_route_size,
    input  o_valid, o_addr, o_data, o_done, o_overrun
  );

  modport slave (
    input  i_psum_out_en, i_en, i_psum, i_route_size,
    output o_valid, o_addr, o_data, o_done, o_overrun
  );
endinterface

// File: rtl/psum_tile_buffer.sv
// Holds one captured partial-sum tile; parallel load, combinational read by word index.
module psum_tile_buffer #(
  parameter int WORDS      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 2
) (
  input  logic                        i_clk,
  input  logic                        i_load,
  input  logic [WORDS*DATA_WIDTH-1:0] i_tile,
  input  logic [IDX_W-1:0]            i_rd_idx,
  output logic [DATA_WIDTH-1:0]       o_rd_data
);
  logic [DATA_WIDTH-1:0] tile_w   [WORDS];
  logic [DATA_WIDTH-1:0] word_reg [WORDS];

  // Unflatten so word k sits at element k (row-major r*COLS+c).
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_unpack
    assign tile_w[gi] = i_tile[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge i_clk) begin
    if (i_load) begin
      word_reg <= tile_w;
    end
  end

  assign o_rd_data = word_reg[i_rd_idx];
endmodule

// File: rtl/output_router.sv
// Captures a systolic-array psum tile on strobe and drains it word by word to output memory.
module output_router
  import accel_pkg::*;
#(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_reg_clear,
  output_router_if.slave bus
);
  localparam int TILE_WORDS = tile_words(ROWS, COLS);
  localparam int CNT_W      = $clog2(TILE_WORDS + 1);
  localparam int IDX_W      = (TILE_WORDS > 1) ? $clog2(TILE_WORDS) : 1;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [CNT_W-1:0]        size_reg, size_next;
  logic [CNT_W-1:0]        size_clamped;
  logic [ADDR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    valid_reg, valid_next;
  logic                    done_reg, done_next;
  logic                    overrun_reg, overrun_next;
  logic                    load;
  logic                    clear;

  assign clear = i_rst | i_reg_clear;

  always_comb begin
    if (bus.i_route_size > ADDR_WIDTH'(TILE_WORDS)) begin
      size_clamped = CNT_W'(TILE_WORDS);
    end else begin
      size_clamped = bus.i_route_size[CNT_W-1:0];
    end
  end

  psum_tile_buffer #(
    .WORDS      (TILE_WORDS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_tile_buffer (
    .i_clk     (i_clk),
    .i_load    (load),
    .i_tile    (bus.i_psum),
    .i_rd_idx  (cnt_reg[IDX_W-1:0]),
    .o_rd_data (rd_data)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    size_next    = size_reg;
    wr_ptr_next  = wr_ptr_reg;
    valid_next   = 1'b0;
    addr_next    = addr_reg;
    data_next    = data_reg;
    done_next    = done_reg;
    overrun_next = overrun_reg;
    load         = 1'b0;

    unique case (state_reg)
      IDLE, DONE: begin
        // Done rises on the edge after entering DONE, so a zero-size tile also reports one cycle late.
        if (state_reg == DONE) done_next = 1'b1;
        if (bus.i_psum_out_en) begin
          load       = !clear;
          size_next  = size_clamped;
          cnt_next   = '0;
          done_next  = 1'b0;
          state_next = (size_clamped == '0) ? DONE : LOADED;
        end
      end
      LOADED, DRAIN: begin
        if (bus.i_psum_out_en) overrun_next = 1'b1;
        if (bus.i_en) begin
          valid_next  = 1'b1;
          data_next   = rd_data;
          addr_next   = wr_ptr_reg;
          cnt_next    = cnt_reg + CNT_W'(1);
          wr_ptr_next = wr_ptr_reg + ADDR_WIDTH'(1);
          state_next  = (cnt_reg == size_reg - CNT_W'(1)) ? DONE : DRAIN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (clear) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      size_reg    <= '0;
      wr_ptr_reg  <= '0;
      valid_reg   <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      size_reg    <= size_next;
      wr_ptr_reg  <= wr_ptr_next;
      valid_reg   <= valid_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
    end
  end

  assign bus.o_valid   = valid_reg;
  assign bus.o_addr    = addr_reg;
  assign bus.o_data    = data_reg;
  assign bus.o_done    = done_reg;
  assign bus.o_overrun = overrun_reg;
endmodule

// File: tb/tb_output_router.sv
// Directed, table-driven bench for output_router (2x2 tile, 16-bit data, 8-bit addresses).
module tb_output_router;
  localparam logic [63:0] T1 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] T2 = 64'h0013_0012_0011_0010;
  localparam logic [63:0] T3 = 64'h0023_0022_0021_0020;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  output_router_if #(.ROWS(2), .COLS(2), .DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

  output_router #(.ROWS(2), .COLS(2), .DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_reg_clear (clr),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, clr, pe, en;
    logic [63:0] psum;
    logic [7:0]  size;
    logic        ev;
    logic [7:0]  ea;
    logic [15:0] ed;
    logic        edone, eovr, chk_ad;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, c, pe, en, input logic [63:0] psum, input logic [7:0] size,
                     input logic ev, input logic [7:0] ea, input logic [15:0] ed,
                     input logic edone, eovr);
    vec_t v;
    v.rst = r; v.clr = c; v.pe = pe; v.en = en; v.psum = psum; v.size = size;
    v.ev = ev; v.ea = ea; v.ed = ed; v.edone = edone; v.eovr = eovr;
    v.chk_ad = ev | r | c;
    vecs.push_back(v);
  endtask

  task automatic wr(input logic [7:0] ea, input logic [15:0] ed, input logic eovr);
    add(0, 0, 0, 1, 64'h0, 8'd0, 1, ea, ed, 0, eovr);
  endtask

  task automatic nv(input logic en, input logic edone, input logic eovr);
    add(0, 0, 0, en, 64'h0, 8'd0, 0, 8'h0, 16'h0, edone, eovr);
  endtask

  task automatic cap(input logic [63:0] psum, input logic [7:0] size);
    add(0, 0, 1, 1, psum, size, 0, 8'h0, 16'h0, 0, 0);
  endtask

  task automatic rst_row();
    add(1, 0, 0, 1, 64'h0, 8'd0, 0, 8'h0, 16'h0, 0, 0);
  endtask

  initial begin
    int nvalid;
    int last_valid;
    int done_at;

    rst = 1'b1; clr = 1'b0;
    bus.i_psum_out_en = 1'b0; bus.i_en = 1'b0; bus.i_psum = '0; bus.i_route_size = '0;

    // Basic tile, then back-to-back tiles with clamping and contiguous addresses
    rst_row();
    cap(T1, 8'd4); wr(0, 16'h1, 0); wr(1, 16'h2, 0); wr(2, 16'h3, 0); wr(3, 16'h4, 0);
    nv(1, 1, 0); nv(0, 1, 0);
    cap(T2, 8'd2); wr(4, 16'h10, 0); wr(5, 16'h11, 0); nv(1, 1, 0);
    cap(T3, 8'd9); wr(6, 16'h20, 0); wr(7, 16'h21, 0); wr(8, 16'h22, 0); wr(9, 16'h23, 0);
    nv(1, 1, 0);
    // Pause for three cycles after word 1
    rst_row();
    cap(T1, 8'd4); wr(0, 16'h1, 0); wr(1, 16'h2, 0);
    nv(0, 0, 0); nv(0, 0, 0); nv(0, 0, 0);
    wr(2, 16'h3, 0); wr(3, 16'h4, 0); nv(1, 1, 0);
    // Zero-size tile
    cap(T2, 8'd0); nv(1, 1, 0); nv(0, 1, 0);
    // Overrun during drain, then clear together with a strobe
    cap(T1, 8'd4); wr(4, 16'h1, 0);
    add(0, 0, 1, 1, T2, 8'd4, 1, 8'd5, 16'h2, 0, 1);
    wr(6, 16'h3, 1); wr(7, 16'h4, 1); nv(1, 1, 1);
    add(0, 1, 1, 1, T3, 8'd4, 0, 8'h0, 16'h0, 0, 0);
    nv(1, 0, 0); nv(1, 0, 0);
    cap(T2, 8'd4); wr(0, 16'h10, 0); wr(1, 16'h11, 0);
    // Reset mid-drain
    rst_row(); nv(1, 0, 0); nv(1, 0, 0);
    cap(T3, 8'd1); wr(0, 16'h20, 0); nv(1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; clr = vecs[i].clr;
      bus.i_psum_out_en = vecs[i].pe; bus.i_en = vecs[i].en;
      bus.i_psum = vecs[i].psum; bus.i_route_size = vecs[i].size;
      @(posedge clk);
      #1;
      $display("vec %0d: valid=%0b addr=%0h data=%0h done=%0b ovr=%0b", i,
               bus.o_valid, bus.o_addr, bus.o_data, bus.o_done, bus.o_overrun);
      cmp($sformatf("vec%0d valid", i), 32'(bus.o_valid), 32'(vecs[i].ev));
      cmp($sformatf("vec%0d done", i), 32'(bus.o_done), 32'(vecs[i].edone));
      cmp($sformatf("vec%0d overrun", i), 32'(bus.o_overrun), 32'(vecs[i].eovr));
      if (vecs[i].chk_ad) begin
        cmp($sformatf("vec%0d addr", i), 32'(bus.o_addr), 32'(vecs[i].ea));
        cmp($sformatf("vec%0d data", i), 32'(bus.o_data), 32'(vecs[i].ed));
      end
    end

    // Free-running tile: count writes and check done follows the last write by one cycle
    rst = 1'b1; clr = 1'b0; bus.i_psum_out_en = 1'b0; bus.i_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_psum = T2; bus.i_route_size = 8'd4; bus.i_psum_out_en = 1'b1; bus.i_en = 1'b1;
    @(posedge clk); #1;
    bus.i_psum_out_en = 1'b0;
    nvalid = 0; last_valid = -1; done_at = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.o_valid) begin
        nvalid++;
        last_valid = c;
      end
      if (bus.o_done) begin
        done_at = c;
        break;
      end
    end
    $display("seq: writes=%0d last_valid=%0d done_at=%0d", nvalid, last_valid, done_at);
    cmp("seq done seen", 32'(done_at >= 0), 32'd1);
    cmp("seq write count", 32'(nvalid), 32'd4);
    cmp("seq done latency", 32'(done_at - last_valid), 32'd1);
    bus.i_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      cmp($sformatf("seq done hold %0d", c), 32'(bus.o_done), 32'd1);
      cmp($sformatf("seq idle valid %0d", c), 32'(bus.o_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
